pipe_slice_n: RTL and testbench
===============================

Name: pipe_slice_n

Overview:
- Parametrised valid/ready pipeline register chain carrying a DATA_W payload through DEPTH register slices.
- Successor to the single-bit control-only slice. Adds:
  - a data path;
  - selectable slice mode: pass-through ready, or a skid buffer with registered ready;
  - synchronous flush;
  - an occupancy count.
- Inserted between pipeline units (fetch→decode, decode→execute, memory response paths) to break timing paths without losing throughput.

Parameters:
- DATA_W, 32, payload width in bits (≥1).
- DEPTH, 1, number of cascaded slices (≥1).
- SKID, 0. 0 = simple slices, where ready_o is combinational from downstream. 1 = skid slices, where ready_o is registered in every slice.
- OCC_W, $clog2(2*DEPTH+1), width of occupancy output.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-low; sampled on rising clk.
- valid_i  input  1  upstream payload valid.
- data_i  input  DATA_W  upstream payload.
- ready_o  output  1  upstream may transfer (valid_i & ready_o).
- valid_ro  output  1  registered downstream valid.
- data_o  output  DATA_W  registered downstream payload.
- ready_i  input  1  downstream accepts (valid_ro & ready_i).
- flush_i  input  1  synchronous discard of all held entries.
- occ_o  output  OCC_W  count of valid entries held across all slices and skid registers.

Behaviour:
- Reset (rst==0 at a clk edge) clears all per-slice state:
  - every valid and skid-valid bit → 0;
  - data registers → 0;
  - occ_o → 0, valid_ro → 0, data_o → 0.
  - ready_o → 1 after reset in SKID=1. In SKID=0, ready_o = 1 because valid_ro = 0.
  - Reset overrides flush_i and any transfer in the same cycle. Mid-stream reset drops all in-flight payloads without emitting them.
- Transfers:
  - A transfer occurs on an edge where valid & ready are both 1 at that boundary.
  - valid_ro/data_o hold stable while valid_ro & ~ready_i.
  - Payload order is strictly preserved. No payload is duplicated or dropped except by flush or reset.
- Slice k (0 = input side, DEPTH-1 = output side), SKID=0:
  - cke_k = ~v_k | rdy_{k+1}.
  - When cke_k: v_k ← v_{k-1}, d_k ← d_{k-1}.
  - The data register loads only when the incoming valid is 1; it keeps its old value otherwise.
  - rdy_k = cke_k; ready_o = cke_0.
  - The ready chain is combinational through all DEPTH slices.
- Slice k, SKID=1: main register (v_k, d_k) plus skid register (sv_k, sd_k).
  - rdy_k = ~sv_k (registered).
  - Accept in with the main register empty or being drained: load main.
  - Accept in with main full and not draining: load skid.
  - Drain with sv_k=1: main ← skid, sv_k ← 0.
  - Simultaneous drain + accept with sv_k=1 is impossible, because rdy_k = 0.
  - The slice holds up to 2 entries. No combinational path from ready_i to ready_o.
- Latency and throughput:
  - Latency from accept at input to valid_ro = DEPTH cycles, with no backpressure.
  - Sustained throughput is 1 transfer/cycle in both modes.
- Flush (flush_i==1 at edge, rst==1):
  - all v_k, sv_k ← 0; occ_o ← 0;
  - any upstream payload presented that cycle is discarded, but ready_o still reports its normal value so upstream handshake logic sees a transfer;
  - a downstream transfer in the flush cycle still counts as delivered.
  - Next cycle: valid_ro=0, ready_o=1.
- occ_o:
  - registered;
  - +1 on an input transfer, -1 on an output transfer, unchanged on both or neither; 0 after flush or reset;
  - max DEPTH (SKID=0) or 2*DEPTH (SKID=1); never wraps.

Test Plan:
- Reset: hold rst=0 for 3 cycles while valid_i=1, data_i=0xA5A5A5A5 → valid_ro=0, data_o=0, occ_o=0, ready_o=1 throughout and on the first cycle after release.
- Streaming, DEPTH=3, SKID=0/1, ready_i=1: inject 0x01..0x10 back-to-back → first valid_ro 3 cycles after the first accept; 16 consecutive outputs in order; occ_o steady at 3.
- Backpressure, DEPTH=2, SKID=1: stream continuously with ready_i=0 for 6 cycles → ready_o drops after exactly 4 accepts; occ_o=4; data_o frozen at the first word. Then ready_i=1 → words 1..4 drain in order at 1/cycle, and ready_o returns 1 one cycle after the first drain.
- Backpressure, SKID=0, DEPTH=1: with valid_ro=1 and ready_i=0, ready_o=0 in the same cycle. Raising ready_i makes ready_o=1 combinationally, and pass-through continues without a bubble.
- Flush: with occ_o=3, assert flush_i for one cycle while valid_i=1, data_i=0x55 → next cycle valid_ro=0, occ_o=0, ready_o=1; 0x55 never appears at the output.
- Reset mid-operation: apply rst=0 for one cycle during a backpressured full state (SKID=1, DEPTH=2, occ_o=4) → all state clears. Subsequent stream 0x100..0x103 emerges in order with no stale words.

Source files
------------

// File: rtl/pipe_slice_n_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_slice_n_if
//  Purpose  : Valid/ready stream bundle around a pipe_slice_n chain, plus its
//             flush and occupancy side signals. Names are seen from the slice.
//  Revision : 1.0  initial release
// ============================================================================
interface pipe_slice_n_if #(
  parameter int DATA_W = 32,
  parameter int OCC_W  = 2
);
  logic              valid_i;
  logic [DATA_W-1:0] data_i;
  logic              ready_o;
  logic              valid_ro;
  logic [DATA_W-1:0] data_o;
  logic              ready_i;
  logic              flush_i;
  logic [OCC_W-1:0]  occ_o;

  // The slice chain itself
  modport slave (
    input  valid_i, data_i, ready_i, flush_i,
    output ready_o, valid_ro, data_o, occ_o
  );

  // Whoever drives the chain (upstream producer + downstream consumer)
  modport master (
    output valid_i, data_i, ready_i, flush_i,
    input  ready_o, valid_ro, data_o, occ_o
  );
endinterface
`default_nettype wire

// File: rtl/pipe_slice_n.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_slice_n
//  Purpose  : DEPTH cascaded valid/ready register slices carrying a DATA_W
//             payload. SKID=0 gives simple slices with a combinational ready
//             chain; SKID=1 gives two-entry skid slices with registered ready.
//             Synchronous flush and a registered occupancy count.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_slice_n #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1,
  parameter int SKID   = 0,
  parameter int OCC_W  = $clog2(2*DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst,   // active-low, synchronous
  pipe_slice_n_if.slave bus
);

  // Main register of every slice; index DEPTH-1 faces downstream.
  logic [DEPTH-1:0]  r_v;
  logic [DATA_W-1:0] r_d    [DEPTH];
  // What each slice sees coming in from its upstream neighbour.
  logic [DEPTH-1:0]  w_in_v;
  logic [DATA_W-1:0] w_in_d [DEPTH];
  logic              w_rdy_up;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic [OCC_W-1:0]  r_occ;

  // Slice 0 is fed by the port, every later slice by its predecessor's main register
  always_comb begin
    w_in_v[0] = bus.valid_i;
    w_in_d[0] = bus.data_i;
    for (int k = 1; k < DEPTH; k++) begin
      w_in_v[k] = r_v[k-1];
      w_in_d[k] = r_d[k-1];
    end
  end

  if (SKID == 0) begin : g_simple
    logic [DEPTH-1:0] w_cke;
    logic             w_room;

    // A slice may load when it, or any slice after it, is empty, or downstream takes
    always_comb begin
      w_room = bus.ready_i;
      w_cke  = '0;
      for (int k = DEPTH-1; k >= 0; k--) begin
        w_room   = w_room | ~r_v[k];
        w_cke[k] = w_room;
      end
    end

    assign w_rdy_up = w_cke[0];

    // Advance each enabled slice; data only captures real payloads
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_v <= '0;
        for (int k = 0; k < DEPTH; k++) r_d[k] <= '0;
      end else begin
        for (int k = 0; k < DEPTH; k++) begin
          if (w_cke[k]) begin
            r_v[k] <= w_in_v[k];
            if (w_in_v[k]) r_d[k] <= w_in_d[k];
          end
        end
        if (bus.flush_i) r_v <= '0;
      end
    end
  end else begin : g_skid
    logic [DEPTH-1:0]  r_sv;
    logic [DATA_W-1:0] r_sd [DEPTH];
    logic [DEPTH:0]    w_rdy_chain;  // [k] = ready offered to slice k-1's output
    logic [DEPTH-1:0]  w_out_rdy;
    logic [DEPTH-1:0]  w_acc;
    logic [DEPTH-1:0]  w_drn;

    // Each slice is ready exactly when its skid register is free
    assign w_rdy_chain = {bus.ready_i, ~r_sv};
    assign w_out_rdy   = w_rdy_chain[DEPTH:1];
    assign w_acc       = w_in_v & ~r_sv;
    assign w_drn       = r_v & w_out_rdy;
    assign w_rdy_up    = ~r_sv[0];

    // Main/skid update: drain refills main from skid, a blocked accept parks in skid
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_v  <= '0;
        r_sv <= '0;
        for (int k = 0; k < DEPTH; k++) begin
          r_d[k]  <= '0;
          r_sd[k] <= '0;
        end
      end else if (bus.flush_i) begin
        r_v  <= '0;
        r_sv <= '0;
      end else begin
        for (int k = 0; k < DEPTH; k++) begin
          if (w_drn[k]) begin
            if (r_sv[k]) begin
              // ready was low, so no accept can coincide with this refill
              r_d[k]  <= r_sd[k];
              r_sv[k] <= 1'b0;
            end else begin
              r_v[k] <= w_acc[k];
              if (w_acc[k]) r_d[k] <= w_in_d[k];
            end
          end else if (w_acc[k]) begin
            if (r_v[k]) begin
              r_sv[k] <= 1'b1;
              r_sd[k] <= w_in_d[k];
            end else begin
              r_v[k] <= 1'b1;
              r_d[k] <= w_in_d[k];
            end
          end
        end
      end
    end
  end

  assign w_in_xfer  = bus.valid_i & w_rdy_up;
  assign w_out_xfer = r_v[DEPTH-1] & bus.ready_i;

  // Occupancy tracks boundary handshakes; both or neither leaves it unchanged
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_occ <= '0;
    end else if (bus.flush_i) begin
      r_occ <= '0;
    end else if (w_in_xfer && !w_out_xfer) begin
      r_occ <= r_occ + OCC_W'(1);
    end else if (!w_in_xfer && w_out_xfer) begin
      r_occ <= r_occ - OCC_W'(1);
    end
  end

  assign bus.ready_o  = w_rdy_up;
  assign bus.valid_ro = r_v[DEPTH-1];
  assign bus.data_o   = r_d[DEPTH-1];
  assign bus.occ_o    = r_occ;

endmodule
`default_nettype wire

// File: tb/tb_pipe_slice_n.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_slice_n
//  Purpose  : Self-checking bench for pipe_slice_n. Four instances share one
//             stimulus: A (DEPTH=3,SKID=0), B (DEPTH=3,SKID=1),
//             C (DEPTH=2,SKID=1), D (DEPTH=1,SKID=0). A queue model per
//             instance checks order, content, occupancy and capacity.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_slice_n;

  logic        clk;
  logic        s_rst;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        s_flush;
  int          total = 0;
  int          bad   = 0;
  bit          mon_en = 1'b0;

  pipe_slice_n_if #(.DATA_W(32), .OCC_W(3)) if_a ();
  pipe_slice_n_if #(.DATA_W(32), .OCC_W(3)) if_b ();
  pipe_slice_n_if #(.DATA_W(32), .OCC_W(3)) if_c ();
  pipe_slice_n_if #(.DATA_W(32), .OCC_W(2)) if_d ();

  assign if_a.valid_i = s_valid; assign if_a.data_i = s_data;
  assign if_a.ready_i = s_ready; assign if_a.flush_i = s_flush;
  assign if_b.valid_i = s_valid; assign if_b.data_i = s_data;
  assign if_b.ready_i = s_ready; assign if_b.flush_i = s_flush;
  assign if_c.valid_i = s_valid; assign if_c.data_i = s_data;
  assign if_c.ready_i = s_ready; assign if_c.flush_i = s_flush;
  assign if_d.valid_i = s_valid; assign if_d.data_i = s_data;
  assign if_d.ready_i = s_ready; assign if_d.flush_i = s_flush;

  pipe_slice_n #(.DATA_W(32), .DEPTH(3), .SKID(0), .OCC_W(3)) u_a (.clk(clk), .rst(s_rst), .bus(if_a));
  pipe_slice_n #(.DATA_W(32), .DEPTH(3), .SKID(1), .OCC_W(3)) u_b (.clk(clk), .rst(s_rst), .bus(if_b));
  pipe_slice_n #(.DATA_W(32), .DEPTH(2), .SKID(1), .OCC_W(3)) u_c (.clk(clk), .rst(s_rst), .bus(if_c));
  pipe_slice_n #(.DATA_W(32), .DEPTH(1), .SKID(0), .OCC_W(2)) u_d (.clk(clk), .rst(s_rst), .bus(if_d));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model: one FIFO per instance ----------------
  logic [31:0] mq  [4][64];
  int          mhd [4] = '{0, 0, 0, 0};
  int          mtl [4] = '{0, 0, 0, 0};

  task automatic mon_chk(input int id, input logic rdy, input logic vro,
                         input logic [31:0] dout, input int occ, input int cap);
    int cnt;
    cnt = mtl[id] - mhd[id];
    total++;
    if (occ != cnt) begin
      bad++;
      $display("FAIL mon_occ dut=%0d got=%0d want=%0d t=%0t", id, occ, cnt, $time);
    end
    if (vro) begin
      total++;
      if (cnt == 0) begin
        bad++;
        $display("FAIL mon_data dut=%0d got=%h want=none(empty) t=%0t", id, dout, $time);
      end else if (dout !== mq[id][mhd[id] & 63]) begin
        bad++;
        $display("FAIL mon_data dut=%0d got=%h want=%h t=%0t", id, dout, mq[id][mhd[id] & 63], $time);
      end
    end
    // apply this edge's events to the model
    if (!s_rst) begin
      mhd[id] = 0;
      mtl[id] = 0;
    end else begin
      if (vro && s_ready && cnt > 0) mhd[id]++;
      if (s_flush) begin
        mhd[id] = mtl[id];
      end else if (s_valid && rdy) begin
        mq[id][mtl[id] & 63] = s_data;
        mtl[id]++;
        total++;
        if (mtl[id] - mhd[id] > cap) begin
          bad++;
          $display("FAIL mon_cap dut=%0d got=%0d want<=%0d t=%0t", id, mtl[id] - mhd[id], cap, $time);
        end
      end
    end
  endtask

  // Sample one time unit before each rising edge
  always @(negedge clk) begin
    #4;
    if (mon_en) begin
      mon_chk(0, if_a.ready_o, if_a.valid_ro, if_a.data_o, int'(if_a.occ_o), 3);
      mon_chk(1, if_b.ready_o, if_b.valid_ro, if_b.data_o, int'(if_b.occ_o), 6);
      mon_chk(2, if_c.ready_o, if_c.valid_ro, if_c.data_o, int'(if_c.occ_o), 4);
      mon_chk(3, if_d.ready_o, if_d.valid_ro, if_d.data_o, int'(if_d.occ_o), 1);
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_out(input string nm, input logic rdy, input logic vro,
                         input logic [31:0] dout, input int occ,
                         input logic e_rdy, input logic e_vro,
                         input logic [31:0] e_d, input int e_occ, input bit use_d);
    chk({nm, ".ready_o"},  32'(rdy), 32'(e_rdy));
    chk({nm, ".valid_ro"}, 32'(vro), 32'(e_vro));
    chk({nm, ".occ_o"},    32'(occ), 32'(e_occ));
    if (use_d) chk({nm, ".data_o"}, dout, e_d);
  endtask

  task automatic chk_idle(input string nm);
    chk_out({nm, "_a"}, if_a.ready_o, if_a.valid_ro, if_a.data_o, int'(if_a.occ_o), 1'b1, 1'b0, 32'd0, 0, 1'b0);
    chk_out({nm, "_b"}, if_b.ready_o, if_b.valid_ro, if_b.data_o, int'(if_b.occ_o), 1'b1, 1'b0, 32'd0, 0, 1'b0);
    chk_out({nm, "_c"}, if_c.ready_o, if_c.valid_ro, if_c.data_o, int'(if_c.occ_o), 1'b1, 1'b0, 32'd0, 0, 1'b0);
    chk_out({nm, "_d"}, if_d.ready_o, if_d.valid_ro, if_d.data_o, int'(if_d.occ_o), 1'b1, 1'b0, 32'd0, 0, 1'b0);
  endtask

  task automatic do_reset();
    s_rst   = 1'b0;
    s_valid = 1'b0;
    s_flush = 1'b0;
    tick();
    s_rst   = 1'b1;
  endtask

  // ---------------- backpressure vector table for instance C ----------------
  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        ri;
    logic        e_rdy;
    logic        e_vro;
    logic [31:0] e_d;
    int          e_occ;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int got;

    tbl[0]  = '{1'b1, 32'd1, 1'b0, 1'b1, 1'b0, 32'd0, 0};
    tbl[1]  = '{1'b1, 32'd2, 1'b0, 1'b1, 1'b0, 32'd0, 1};
    tbl[2]  = '{1'b1, 32'd3, 1'b0, 1'b1, 1'b1, 32'd1, 2};
    tbl[3]  = '{1'b1, 32'd4, 1'b0, 1'b1, 1'b1, 32'd1, 3};
    tbl[4]  = '{1'b1, 32'd5, 1'b0, 1'b0, 1'b1, 32'd1, 4};
    tbl[5]  = '{1'b1, 32'd5, 1'b0, 1'b0, 1'b1, 32'd1, 4};
    tbl[6]  = '{1'b1, 32'd5, 1'b1, 1'b0, 1'b1, 32'd1, 4};
    tbl[7]  = '{1'b1, 32'd5, 1'b1, 1'b0, 1'b1, 32'd2, 3};
    tbl[8]  = '{1'b1, 32'd5, 1'b1, 1'b1, 1'b1, 32'd3, 2};
    tbl[9]  = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'd4, 2};
    tbl[10] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 32'd5, 1};
    tbl[11] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0, 0};

    // -------- reset held 3 cycles with a payload presented --------
    s_rst = 1'b0; s_valid = 1'b1; s_data = 32'hA5A5A5A5; s_ready = 1'b0; s_flush = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      mon_en = 1'b1;
      #2;
      chk_idle($sformatf("rst%0d", c));
      chk("rst_a.data_o", if_a.data_o, 32'd0);
      chk("rst_b.data_o", if_b.data_o, 32'd0);
      chk("rst_c.data_o", if_c.data_o, 32'd0);
      chk("rst_d.data_o", if_d.data_o, 32'd0);
    end
    s_rst = 1'b1; s_valid = 1'b0;
    tick();
    #2;
    chk_idle("rel");

    // -------- streaming 0x01..0x10 through the DEPTH=3 instances --------
    do_reset();
    s_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      s_valid = (j < 16);
      s_data  = 32'(j + 1);
      #2;
      chk($sformatf("str%0d_a.vro", j), 32'(if_a.valid_ro), 32'(j >= 3 && j <= 18));
      chk($sformatf("str%0d_b.vro", j), 32'(if_b.valid_ro), 32'(j >= 3 && j <= 18));
      chk($sformatf("str%0d_a.rdy", j), 32'(if_a.ready_o), 32'd1);
      chk($sformatf("str%0d_b.rdy", j), 32'(if_b.ready_o), 32'd1);
      if (j >= 3 && j <= 18) begin
        chk($sformatf("str%0d_a.data", j), if_a.data_o, 32'(j - 2));
        chk($sformatf("str%0d_b.data", j), if_b.data_o, 32'(j - 2));
      end
      if (j >= 3 && j <= 16) begin
        chk($sformatf("str%0d_a.occ", j), 32'(if_a.occ_o), 32'd3);
        chk($sformatf("str%0d_b.occ", j), 32'(if_b.occ_o), 32'd3);
      end
      tick();
    end

    // -------- table: skid backpressure on C (DEPTH=2, SKID=1) --------
    do_reset();
    for (int r = 0; r < 12; r++) begin
      s_valid = tbl[r].v;
      s_data  = tbl[r].d;
      s_ready = tbl[r].ri;
      #2;
      chk_out($sformatf("tbl%0d_c", r), if_c.ready_o, if_c.valid_ro, if_c.data_o, int'(if_c.occ_o),
              tbl[r].e_rdy, tbl[r].e_vro, tbl[r].e_d, tbl[r].e_occ, tbl[r].e_vro);
      tick();
    end

    // -------- D (DEPTH=1, SKID=0): combinational ready, no bubble --------
    do_reset();
    s_valid = 1'b1; s_data = 32'h11; s_ready = 1'b0;
    #2;
    chk("pt0_d.rdy", 32'(if_d.ready_o), 32'd1);
    tick();
    s_data = 32'h22;
    #2;
    chk_out("pt1_d", if_d.ready_o, if_d.valid_ro, if_d.data_o, int'(if_d.occ_o), 1'b0, 1'b1, 32'h11, 1, 1'b1);
    s_ready = 1'b1;
    #1;
    chk("pt1_d.rdy_comb", 32'(if_d.ready_o), 32'd1);
    tick();
    s_data = 32'h33;
    #2;
    chk_out("pt2_d", if_d.ready_o, if_d.valid_ro, if_d.data_o, int'(if_d.occ_o), 1'b1, 1'b1, 32'h22, 1, 1'b1);
    tick();
    s_valid = 1'b0;
    #2;
    chk_out("pt3_d", if_d.ready_o, if_d.valid_ro, if_d.data_o, int'(if_d.occ_o), 1'b1, 1'b1, 32'h33, 1, 1'b1);
    tick();
    #2;
    chk_out("pt4_d", if_d.ready_o, if_d.valid_ro, if_d.data_o, int'(if_d.occ_o), 1'b1, 1'b0, 32'd0, 0, 1'b0);

    // -------- flush with occ=3 on B while 0x55 is offered --------
    do_reset();
    s_ready = 1'b0; s_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      s_data = 32'h11 * (j + 1);
      tick();
    end
    s_data = 32'h55; s_flush = 1'b1;
    #2;
    chk("fl_b.occ_pre", 32'(if_b.occ_o), 32'd3);
    chk("fl_b.rdy_pre", 32'(if_b.ready_o), 32'd1);
    tick();
    s_flush = 1'b0; s_valid = 1'b0;
    #2;
    chk_idle("fl_post");
    s_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick();
      #2;
      chk($sformatf("fl%0d_a.vro", j), 32'(if_a.valid_ro), 32'd0);
      chk($sformatf("fl%0d_b.vro", j), 32'(if_b.valid_ro), 32'd0);
    end

    // -------- reset during a full backpressured state on C --------
    do_reset();
    s_ready = 1'b0; s_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      s_data = 32'hA1 + 32'(j);
      tick();
    end
    s_valid = 1'b0;
    #2;
    chk_out("mid_full_c", if_c.ready_o, if_c.valid_ro, if_c.data_o, int'(if_c.occ_o), 1'b0, 1'b1, 32'hA1, 4, 1'b1);
    s_rst = 1'b0;
    tick();
    s_rst = 1'b1;
    #2;
    chk_out("mid_clr_c", if_c.ready_o, if_c.valid_ro, if_c.data_o, int'(if_c.occ_o), 1'b1, 1'b0, 32'd0, 0, 1'b1);
    tick();
    got = 0;
    s_ready = 1'b1;
    for (int j = 0; j < 12; j++) begin
      s_valid = (j < 4);
      s_data  = 32'h100 + 32'(j);
      #2;
      if (if_c.valid_ro) begin
        chk($sformatf("mid_out%0d_c", got), if_c.data_o, 32'h100 + 32'(got));
        got++;
      end
      tick();
    end
    chk("mid_count_c", 32'(got), 32'd4);

    // -------- randomized traffic against the queue model --------
    for (int n = 0; n < 3000; n++) begin
      s_valid = ($urandom_range(3) != 0);
      s_data  = $urandom;
      s_ready = (n % 600 < 300) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      s_flush = ($urandom_range(49) == 0);
      s_rst   = ($urandom_range(399) != 0);
      tick();
    end
    do_reset();
    tick();
    #2;
    chk_idle("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
